// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the digit-serial ALU
// Purpose: operation select codes and FSM state codes used by alu_serial,
//          alu_digit and the bench.
// Ports:   none (package).
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_AND = 2'b01;
  localparam alu_op_t ALU_OR  = 2'b10;
  localparam alu_op_t ALU_XOR = 2'b11;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/alu_serial_if.sv
// rtl/alu_serial_if.sv - start/busy/done request bus of the serial ALU
// Purpose: bundles the operation request and the registered result/status.
// Ports:   master drives start, op, a, b, aen, binv, cin;
//          slave drives busy, done, result, cout, ovf, zero.
interface alu_serial_if #(parameter int WIDTH = 8);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             aen;
  logic             binv;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b, aen, binv, cin,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b, aen, binv, cin,
    output busy, done, result, cout, ovf, zero
  );

endinterface

// File: rtl/alu_digit.sv
// rtl/alu_digit.sv - combinational DIGIT-bit ALU slice
// Purpose: ripple of 1-bit add slices plus the bitwise-op mux for one digit.
// Ports:   a, b  - DIGIT-bit effective operand slices
//          cin   - carry into the digit LSB
//          op    - operation select
//          res   - DIGIT-bit digit result
//          cout  - carry out of the digit MSB
//          ctop  - carry into the digit MSB (signed overflow on the last digit)
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  alu_op_t          op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             ctop
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  always_comb begin
    res = s;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      default: res = s;
    endcase
  end

  assign cout = c[DIGIT];
  assign ctop = c[DIGIT-1];

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - digit-serial ALU, WIDTH bits in WIDTH/DIGIT cycles
// Purpose: latches effective operands on start, processes one DIGIT-bit slice
//          per cycle LSB first, then registers result and flags with a done pulse.
// Ports:   clk   - rising-edge clock
//          reset - synchronous active-high reset, aborts any operation
//          bus   - alu_serial_if slave (request in, result/status out)
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic         clk,
  input logic         reset,
  alu_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  alu_op_t          op_r;
  logic             carry;

  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  logic [DIGIT-1:0]       d_res;
  logic                   d_cout;
  logic                   d_ctop;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   last;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .op   (op_r),
    .res  (d_res),
    .cout (d_cout),
    .ctop (d_ctop)
  );

  // New digit enters at the top and the accumulator shifts right, so after N
  // digits the first (LSB) digit has reached bit 0. Written as a concatenation
  // so WIDTH == DIGIT needs no special case.
  assign acc_cat  = {d_res, acc};
  assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      op_r     <= ALU_ADD;
      carry    <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a & {WIDTH{bus.aen}};
            b_sh  <= bus.b ^ {WIDTH{bus.binv}};
            op_r  <= bus.op;
            carry <= bus.cin;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= d_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            state    <= IDLE;
            done_r   <= 1'b1;
            result_r <= acc_next;
            cout_r   <= (op_r == ALU_ADD) & d_cout;
            ovf_r    <= (op_r == ALU_ADD) & (d_ctop ^ d_cout);
            zero_r   <= (acc_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;
  assign bus.zero   = zero_r;

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - self-checking bench for alu_serial (DIGIT=1 and DIGIT=4)
module tb_alu_serial;
  import alu_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op    = ALU_ADD;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  logic       aen   = 1'b1;
  logic       binv  = 1'b0;
  logic       cin   = 1'b0;
  logic       sel   = 1'b0;

  int checks   = 0;
  int failures = 0;

  alu_serial_if #(.WIDTH(8)) if1 ();
  alu_serial_if #(.WIDTH(8)) if4 ();

  assign if1.start = start & ~sel;
  assign if4.start = start & sel;
  assign if1.op = op;   assign if4.op = op;
  assign if1.a = a;     assign if4.a = a;
  assign if1.b = b;     assign if4.b = b;
  assign if1.aen = aen; assign if4.aen = aen;
  assign if1.binv = binv; assign if4.binv = binv;
  assign if1.cin = cin; assign if4.cin = cin;

  alu_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  alu_serial #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  always #5 clk = ~clk;

  logic       o_busy, o_done, o_cout, o_ovf, o_zero;
  logic [7:0] o_result;
  always_comb begin
    o_busy = sel ? if4.busy : if1.busy;
    o_done = sel ? if4.done : if1.done;
    o_result = sel ? if4.result : if1.result;
    o_cout = sel ? if4.cout : if1.cout;
    o_ovf  = sel ? if4.ovf : if1.ovf;
    o_zero = sel ? if4.zero : if1.zero;
  end

  typedef struct packed {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model(logic [1:0] m_op, logic [7:0] m_a, logic [7:0] m_b,
                                 logic m_aen, logic m_binv, logic m_cin);
    logic [7:0] ea, eb;
    logic [8:0] sum;
    exp_t e;
    ea = m_aen ? m_a : 8'h00;
    eb = m_binv ? ~m_b : m_b;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (m_op)
      ALU_ADD: begin
        sum = {1'b0, ea} + {1'b0, eb} + {8'h00, m_cin};
        e.res  = sum[7:0];
        e.cout = sum[8];
        e.ovf  = (ea[7] == eb[7]) && (e.res[7] != ea[7]);
      end
      ALU_AND: e.res = ea & eb;
      ALU_OR:  e.res = ea | eb;
      default: e.res = ea ^ eb;
    endcase
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one request for one cycle; the accepting edge is consumed here.
  task automatic start_op(input logic [1:0] s_op, input logic [7:0] s_a, input logic [7:0] s_b,
                          input logic s_aen, input logic s_binv, input logic s_cin, input bit push);
    op = s_op; a = s_a; b = s_b; aen = s_aen; binv = s_binv; cin = s_cin;
    start = 1'b1;
    if (push) exp_q.push_back(model(s_op, s_a, s_b, s_aen, s_binv, s_cin));
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checks latency, then pops and compares.
  task automatic finish_op(input string tag, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_done"}, o_done, 1'b1);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_result"}, o_result, e.res);
      chk({tag, "_cout"}, o_cout, e.cout);
      chk({tag, "_ovf"}, o_ovf, e.ovf);
      chk({tag, "_zero"}, o_zero, e.zero);
    end
  endtask

  initial begin
    int dones;
    logic [7:0] held;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_result", o_result, 8'h00);
    chk("rst_cout", o_cout, 1'b0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_zero", o_zero, 1'b1);
    reset = 1'b0;
    tick();

    // ADD with signed overflow
    start_op(ALU_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("add_busy_after_accept", o_busy, 1'b1);
    finish_op("add_7f_01", 8);
    tick();
    chk("done_single_pulse", o_done, 1'b0);
    chk("result_holds", o_result, 8'h80);

    // SUB equal operands
    start_op(ALU_ADD, 8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1);
    finish_op("sub_05_05", 8);

    // aen=0 with logic ops
    start_op(ALU_XOR, 8'h3C, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    finish_op("xor_aen0", 8);
    start_op(ALU_AND, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    finish_op("and_aen0", 8);
    start_op(ALU_OR, 8'hFF, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_op("or_aen0_binv", 8);

    // A few random operations
    for (int i = 0; i < 4; i++) begin
      start_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      finish_op("random_op", 8);
    end

    // start while busy is ignored
    start_op(ALU_ADD, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    start_op(ALU_AND, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_op("busy_start_ignored", 5);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_done) dones++;
    end
    chk("no_extra_done", dones, 0);

    // start during the done cycle is accepted; next done 9 cycles later
    start_op(ALU_ADD, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    finish_op("b2b_first", 8);
    start_op(ALU_XOR, 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy_after_done_start", o_busy, 1'b1);
    finish_op("b2b_second_9_after_first", 8);
    held = o_result;

    // Reset mid-operation aborts it
    start_op(ALU_ADD, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_reset_result_held", o_result, held);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_result", o_result, 8'h00);
    chk("abort_zero", o_zero, 1'b1);
    chk("abort_cout", o_cout, 1'b0);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // DIGIT=4 instance
    sel = 1'b1;
    #1;
    chk("d4_reset_zero", o_zero, 1'b1);
    start_op(ALU_ADD, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    finish_op("d4_add_ff_01", 2);
    start_op(ALU_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    finish_op("d4_add_7f_01", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised multi-cycle ALU that processes a WIDTH-bit operation DIGIT bits per clock. It extends the team's 1-bit add slice, which has A-enable, B-invert and carry-in controls, with four operations, a start/busy/done handshake and status flags. It serves datapaths where area matters more than latency. Operands are latched at start, and the result register holds its value until the next completed operation.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of DIGIT
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; accepted only when busy=0
- op  input  2  operation select (ADD, AND, OR, XOR), latched at accept
- a  input  WIDTH  operand A, latched at accept
- b  input  WIDTH  operand B, latched at accept
- aen  input  1  A enable; effective A = a & {WIDTH{aen}}
- binv  input  1  B invert; effective B = b ^ {WIDTH{binv}}
- cin  input  1  carry into bit 0 (ADD only)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result/flags updated this cycle
- result  output  WIDTH  last completed result
- cout  output  1  carry out of MSB (ADD), else 0
- ovf  output  1  signed overflow (ADD): carry into MSB XOR cout; else 0
- zero  output  1  result == 0

## Operation
- Effective operands:
  - A' = a & aen
  - B' = b ^ binv
- ADD: result = A' + B' + cin, modulo 2^WIDTH.
  - SUB = ADD with binv=1, cin=1.
- AND / OR / XOR: bitwise on A' and B'; cin ignored; cout=0, ovf=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, digit counter 0..N-1.
- IDLE→RUN on start=1. At accept, latch A', B', op, and cin into the internal carry register; the counter clears to 0.
- RUN, each cycle:
  - compute digit [counter*DIGIT +: DIGIT] into an internal shift/accumulate register, LSB digit first;
  - carry register ← digit carry out;
  - on the last digit, also capture the carry into the MSB.
- RUN→IDLE after digit N-1. On that same edge:
  - result ← internal register;
  - cout and ovf update;
  - zero is derived from the new result;
  - done=1 for exactly one cycle.
- start while busy=1 is ignored, with no queueing.
- start during the done cycle (busy=0) is accepted. busy rises on the next edge, so busy shows a one-cycle gap between back-to-back operations.
- Input changes after accept have no effect on the operation in flight.
- reset=1, at any time including mid-operation:
  - abort and return to IDLE;
  - busy=0, done=0, result=0, cout=0, ovf=0, zero=1;
  - the counter and internal registers clear;
  - no done follows for the aborted operation.

## Timing
- Reset values: busy 0, done 0, result 0, cout 0, ovf 0, zero 1.
- start sampled high at edge k (busy=0) gives:
  - busy=1 from edge k through edge k+N;
  - done=1 and new result/flags valid after edge k+N;
  - latency N cycles, throughput one operation per N+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- result, cout, ovf and zero are stable between done pulses.
- Carry chain within one cycle is DIGIT bits deep. Choose DIGIT for timing closure.

## Structure
- Package alu_pkg holds:
  - op encodings: ALU_ADD=2'b00, ALU_AND=2'b01, ALU_OR=2'b10, ALU_XOR=2'b11;
  - state encoding: IDLE, RUN.
- Sub-module alu_digit: combinational, parametrised by DIGIT.
  - Inputs: DIGIT-bit A'/B' slices, carry-in, op.
  - Outputs: DIGIT-bit result, carry out, carry into top bit.
  - Internally a ripple of 1-bit add slices plus the logic-op mux.
- alu_serial holds the FSM, counter, operand shift registers, carry register and output registers.

## Test plan
- WIDTH=8, DIGIT=1, ADD, a=8'h7F, b=8'h01, aen=1, binv=0, cin=0 → after 8 cycles: done pulse, result=8'h80, cout=0, ovf=1, zero=0.
- SUB: a=8'h05, b=8'h05, binv=1, cin=1 → result=8'h00, cout=1, ovf=0, zero=1.
- aen=0 case, b=8'hAA:
  - XOR, binv=0 → result=8'hAA.
  - AND → result=8'h00, zero=1.
  - OR, binv=1 → result=8'h55.
  - In all three, cout=0 and ovf=0.
- Handshake:
  - start pulsed at cycle 3 of a busy operation → ignored; exactly one done.
  - start held during the done cycle → accepted; second done 9 cycles after the first.
- reset asserted on cycle 4 of an ADD:
  - next cycle: busy=0, result=0, zero=1;
  - no done appears within 16 cycles.
- WIDTH=8, DIGIT=4, ADD 8'hFF + 8'h01 → done 2 cycles after accept, result=8'h00, cout=1, ovf=0, zero=1.
